node_mac: RTL and testbench

//  Per-node multiply-accumulate stage: consumes one (coefficient, previous-node data) term per

---
 rtl/node_mac_pkg.sv | 32 +++
 rtl/node_mac_if.sv | 38 +++
 rtl/node_mac_sat.sv | 49 ++++
 rtl/node_mac.sv | 133 +++++++++++++
 tb/tb_node_mac.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/node_mac_pkg.sv
// node_mac_pkg: shared types and constants for the node multiply-accumulate stage.
// Holds the FSM state enum, default widths and the saturation bound helpers.
package node_mac_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int COEF_W_DEF    = 8;
  localparam int FRAC_BITS_DEF = 4;
  localparam int ACC_W_DEF     = 24;

  // term_cnt is 7 bits wide and sticks at its maximum instead of wrapping
  localparam int             CNT_W   = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = 7'd127;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DRAIN  = 3'd2,
    FINISH = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  // Largest value representable in a w-bit two's complement word
  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's complement word
  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/node_mac_if.sv
// node_mac_if: term input stream and node result stream of node_mac, plus FSM state
// for observation. The master modport is the environment side, slave is node_mac.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are both
// high. The sender holds its payload stable while valid is high and ready is low;
// ready may depend on internal state only, never combinationally on valid.
// Term stream: valid=term_valid, ready=term_ready, payload=coef_in/data_in/term_last/bias_in.
// Result stream: valid=out_valid, ready=out_ready, payload=out_data.
interface node_mac_if
  import node_mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COEF_W = COEF_W_DEF
);

  logic                     term_valid;
  logic                     term_last;
  logic                     term_ready;
  logic signed [COEF_W-1:0] coef_in;
  logic signed [DATA_W-1:0] data_in;
  logic signed [DATA_W-1:0] bias_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]         term_cnt;
  state_t                   state;

  modport master (
    output term_valid, term_last, coef_in, data_in, bias_in, out_ready,
    input  term_ready, out_valid, out_data, term_cnt, state
  );

  modport slave (
    input  term_valid, term_last, coef_in, data_in, bias_in, out_ready,
    output term_ready, out_valid, out_data, term_cnt, state
  );

endinterface

// File: rtl/node_mac_sat.sv
// node_mac_sat: combinational back end of a node. Adds the bias (aligned to the
// product's fixed point), drops FRAC_BITS with an arithmetic shift, saturates to
// DATA_W and applies the activation.
// Optional feature macro: NODE_MAC_RELU_EN selects ReLU; otherwise linear activation.
module node_mac_sat
  import node_mac_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF
)(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  output logic signed [DATA_W-1:0] result
);

  // One guard bit so the bias addition can never wrap
  localparam int SW = ACC_W + 1;

  localparam logic signed [SW-1:0]     HI_S  = SW'(sat_max(DATA_W));
  localparam logic signed [SW-1:0]     LO_S  = SW'(sat_min(DATA_W));
  localparam logic signed [DATA_W-1:0] HI_O  = DATA_W'(sat_max(DATA_W));
  localparam logic signed [DATA_W-1:0] LO_O  = DATA_W'(sat_min(DATA_W));

  logic signed [SW-1:0]     bias_ext;
  logic signed [SW-1:0]     sum;
  logic signed [SW-1:0]     shifted;
  logic signed [DATA_W-1:0] sat;

  // Rescale, clamp, then activate
  always_comb begin
    bias_ext = SW'(bias);
    sum      = SW'(acc) + (bias_ext <<< FRAC_BITS);
    shifted  = sum >>> FRAC_BITS;
    if (shifted > HI_S) begin
      sat = HI_O;
    end else if (shifted < LO_S) begin
      sat = LO_O;
    end else begin
      sat = shifted[DATA_W-1:0];
    end
`ifdef NODE_MAC_RELU_EN
    result = sat[DATA_W-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

endmodule

// File: rtl/node_mac.sv
// node_mac: per-node multiply-accumulate. Takes one (coef, data) term per accepted
// cycle, pipelines the product one stage ahead of the accumulator, then on the last
// term adds bias, rescales, saturates and activates, and offers the result on a
// valid/ready output. Accepted term_last at cycle t gives out_valid at t+3.
// Optional feature macro: NODE_MAC_RELU_EN (handled inside node_mac_sat).
module node_mac
  import node_mac_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF
)(
  input logic        clk,
  input logic        rst,
  node_mac_if.slave  bus
);

  localparam int PROD_W = COEF_W + DATA_W;

  state_t state;
  state_t next_state;

  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] prod_new;
  logic signed [ACC_W-1:0]  prod_ext;
  logic                     prod_vld;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [DATA_W-1:0] sat_result;
  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;
  logic [CNT_W-1:0]         term_cnt_q;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     term_ready;
  logic                     accept;

  // Terms are only taken while the accumulator is collecting a node
  assign term_ready = (state == IDLE) || (state == ACCUM);
  assign accept     = bus.term_valid && term_ready;

  // Full-width signed product; no truncation until the final rescale
  assign prod_new = PROD_W'(bus.coef_in) * PROD_W'(bus.data_in);
  assign prod_ext = ACC_W'(prod_q);
  assign cnt_inc  = (term_cnt_q == CNT_MAX) ? CNT_MAX : term_cnt_q + CNT_W'(1);

  node_mac_sat #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_sat (
    .acc    (acc),
    .bias   (bias_q),
    .result (sat_result)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = bus.term_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && bus.term_last) next_state = DRAIN;
      DRAIN:   next_state = FINISH;
      FINISH:  next_state = OUTPUT;
      OUTPUT:  if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: product stage, accumulator, term counter, bias latch and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      prod_q      <= '0;
      prod_vld    <= 1'b0;
      bias_q      <= '0;
      term_cnt_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acc      <= '0;
          prod_vld <= accept;
          if (accept) begin
            prod_q     <= prod_new;
            term_cnt_q <= CNT_W'(1);
            if (bus.term_last) bias_q <= bus.bias_in;
          end
        end
        ACCUM: begin
          if (prod_vld) acc <= acc + prod_ext;
          prod_vld <= accept;
          if (accept) begin
            prod_q     <= prod_new;
            term_cnt_q <= cnt_inc;
            if (bus.term_last) bias_q <= bus.bias_in;
          end
        end
        DRAIN: begin
          if (prod_vld) acc <= acc + prod_ext;
          prod_vld <= 1'b0;
        end
        FINISH: begin
          out_data_q  <= sat_result;
          out_valid_q <= 1'b1;
        end
        OUTPUT: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: begin
          prod_vld <= 1'b0;
        end
      endcase
    end
  end

  assign bus.term_ready = term_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.term_cnt   = term_cnt_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_node_mac.sv
// tb_node_mac: self-checking bench for node_mac. Directed cases from the block's
// worked examples plus randomized nodes checked against an arithmetic reference.
module tb_node_mac;
  import node_mac_pkg::*;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int FB = 4;

  logic clk = 1'b0;
  logic rst;

  node_mac_if #(.DATA_W(DW), .COEF_W(CW)) bus();

  node_mac #(.DATA_W(DW), .COEF_W(CW), .FRAC_BITS(FB), .ACC_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  int node_c[200];
  int node_d[200];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Reference: exact sum of products, bias scaled to the product's fixed point,
  // floor division by 2^FB, clamp to the DATA_W range, optional ReLU.
  function automatic logic [DW-1:0] model_node(input longint sum, input int bias);
    longint t;
    longint r;
    logic [63:0] rv;
    t = sum + longint'(bias) * (longint'(1) << FB);
    if (t >= 0) r = t / (longint'(1) << FB);
    else        r = -((-t + (longint'(1) << FB) - 1) / (longint'(1) << FB));
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
`ifdef NODE_MAC_RELU_EN
    if (r < 0) r = 0;
`endif
    rv = r;
    return rv[DW-1:0];
  endfunction

  // Driver: present one term and hold it until it is accepted. Returns at the
  // negedge following the accepting edge.
  task automatic drive_term(input int c, input int d, input bit last, input int b, output bit ok);
    logic [31:0] cv, dv, bv;
    cv = c; dv = d; bv = b;
    bus.coef_in    = cv[CW-1:0];
    bus.data_in    = dv[DW-1:0];
    bus.bias_in    = bv[DW-1:0];
    bus.term_last  = last;
    bus.term_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.term_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.term_valid = 1'b0;
    bus.term_last  = 1'b0;
  endtask

  // Driver: send node_c/node_d[0..n-1] as one node, optionally with idle gaps
  task automatic send_node(input int n, input int bias, input bit gaps, output longint sum, output bit ok);
    bit t_ok;
    sum = 0;
    ok  = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.coef_in = $urandom_range(0, 255);
        bus.data_in = $urandom_range(0, 255);
        @(negedge clk);
      end
      drive_term(node_c[i], node_d[i], (i == n - 1), bias, t_ok);
      if (!t_ok) ok = 1'b0;
      sum += longint'(node_c[i]) * longint'(node_d[i]);
    end
  endtask

  // Wait (bounded) for out_valid; lat counts negedges waited
  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  // Consume the current result after a number of stalled cycles
  task automatic pop_out(input int delay);
    bus.out_ready = 1'b0;
    repeat (delay) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.term_valid = 1'b0;
    bus.term_last  = 1'b0;
    bus.coef_in    = '0;
    bus.data_in    = '0;
    bus.bias_in    = '0;
    bus.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
    n_checks++;
    if (bus.term_cnt !== 7'd0) begin n_fail++; $display("FAIL reset_term_cnt: got %0d expected 0", bus.term_cnt); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.term_ready !== 1'b1) begin n_fail++; $display("FAIL reset_term_ready: got %0b expected 1", bus.term_ready); end
    n_checks++;
    if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", bus.state); end
  endtask

  // Worked examples with hand-computed results and the t+3 latency
  task automatic test_directed();
    int n, bias, lat;
    logic [DW-1:0] exp_data;
    logic [6:0] exp_cnt;
    longint sum;
    bit ok, w_ok;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin n = 2; node_c[0] = 16; node_d[0] = 32; node_c[1] = 16; node_d[1] = 16;
                 bias = 0; exp_data = 8'd48; exp_cnt = 7'd2; end
        1: begin n = 4; for (int i = 0; i < 4; i++) begin node_c[i] = 127; node_d[i] = 127; end
                 bias = 127; exp_data = 8'd127; exp_cnt = 7'd4; end
        2: begin n = 1; node_c[0] = -16; node_d[0] = 32; bias = 0; exp_cnt = 7'd1;
`ifdef NODE_MAC_RELU_EN
                 exp_data = 8'h00;
`else
                 exp_data = 8'hE0;
`endif
           end
        default: begin n = 1; node_c[0] = 0; node_d[0] = 55; bias = 16; exp_data = 8'd16; exp_cnt = 7'd1; end
      endcase
      send_node(n, bias, 1'b0, sum, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL dir%0d_accept: term not accepted within budget", k); end
      // Negedge after the last accept: DRAIN, then FINISH, then result visible
      n_checks++;
      if (bus.state !== DRAIN || bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_drain: state %0d valid %0b expected DRAIN/0", k, bus.state, bus.out_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus.state !== FINISH || bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_finish: state %0d valid %0b expected FINISH/0", k, bus.state, bus.out_valid);
      end
      @(negedge clk);
      wait_out(lat, w_ok);
      n_checks++;
      if (!w_ok || lat != 0) begin n_fail++; $display("FAIL dir%0d_latency: extra wait %0d ok %0b expected 0 ok 1", k, lat, w_ok); end
      n_checks++;
      if (bus.out_data !== exp_data) begin n_fail++; $display("FAIL dir%0d_data: got %0h expected %0h", k, bus.out_data, exp_data); end
      n_checks++;
      if (bus.term_cnt !== exp_cnt) begin n_fail++; $display("FAIL dir%0d_cnt: got %0d expected %0d", k, bus.term_cnt, exp_cnt); end
      pop_out(0);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.term_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_release: valid %0b ready %0b expected 0/1", k, bus.out_valid, bus.term_ready);
      end
    end
  endtask

  // Output stall with a term waiting upstream
  task automatic test_backpressure();
    longint sum;
    bit ok, w_ok;
    int lat;
    logic [DW-1:0] first_exp, second_exp;
    for (int i = 0; i < 3; i++) begin node_c[i] = 16; node_d[i] = 16; end
    send_node(3, 0, 1'b0, sum, ok);
    first_exp = model_node(sum, 0);
    wait_out(lat, w_ok);
    n_checks++;
    if (!w_ok) begin n_fail++; $display("FAIL bp_wait: out_valid not seen within budget"); end
    // Next node's only term held while the result is stalled
    bus.coef_in    = 8'sd32;
    bus.data_in    = 8'sd40;
    bus.bias_in    = 8'sd0;
    bus.term_last  = 1'b1;
    bus.term_valid = 1'b1;
    second_exp = model_node(32 * 40, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== first_exp) begin
        n_fail++; $display("FAIL bp_hold%0d: valid %0b data %0h expected 1/%0h", i, bus.out_valid, bus.out_data, first_exp);
      end
      n_checks++;
      if (bus.term_ready !== 1'b0 || bus.term_cnt !== 7'd3) begin
        n_fail++; $display("FAIL bp_block%0d: ready %0b cnt %0d expected 0/3", i, bus.term_ready, bus.term_cnt);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.term_ready !== 1'b1 || bus.term_cnt !== 7'd3) begin
      n_fail++; $display("FAIL bp_idle: valid %0b ready %0b cnt %0d expected 0/1/3", bus.out_valid, bus.term_ready, bus.term_cnt);
    end
    @(negedge clk);
    bus.term_valid = 1'b0;
    bus.term_last  = 1'b0;
    n_checks++;
    if (bus.term_cnt !== 7'd1 || bus.state !== DRAIN) begin
      n_fail++; $display("FAIL bp_next_accept: cnt %0d state %0d expected 1/DRAIN", bus.term_cnt, bus.state);
    end
    wait_out(lat, w_ok);
    n_checks++;
    if (!w_ok || bus.out_data !== second_exp) begin
      n_fail++; $display("FAIL bp_second_data: got %0h ok %0b expected %0h", bus.out_data, w_ok, second_exp);
    end
    pop_out($urandom_range(0, 2));
  endtask

  // Asynchronous reset in the middle of a node leaves no residue
  task automatic test_reset_mid();
    bit ok, w_ok;
    int lat;
    longint sum;
    for (int i = 0; i < 3; i++) begin
      drive_term(100, 90 + i, 1'b0, 0, ok);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.term_cnt !== 7'd0 || bus.state !== IDLE) begin
      n_fail++; $display("FAIL rst_mid: valid %0b cnt %0d state %0d expected 0/0/IDLE", bus.out_valid, bus.term_cnt, bus.state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    node_c[0] = 16; node_d[0] = 16;
    send_node(1, 0, 1'b0, sum, ok);
    wait_out(lat, w_ok);
    n_checks++;
    if (!w_ok || bus.out_data !== 8'd16) begin
      n_fail++; $display("FAIL rst_residue: got %0h ok %0b expected 10", bus.out_data, w_ok);
    end
    pop_out(0);
  endtask

  // Randomized nodes through the scoreboard; long node exercises the count ceiling
  task automatic test_random();
    int n, bias, lat;
    longint sum;
    bit ok, w_ok;
    logic [DW-1:0] exp_data;
    logic [6:0] exp_cnt;
    for (int k = 0; k < 24; k++) begin
      n = (k == 12) ? 130 : $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        node_c[i] = int'($urandom_range(0, 255)) - 128;
        node_d[i] = int'($urandom_range(0, 255)) - 128;
      end
      bias = int'($urandom_range(0, 255)) - 128;
      send_node(n, bias, (k % 2) == 1, sum, ok);
      exp_q.push_back(model_node(sum, bias));
      exp_cnt = (n > 127) ? 7'd127 : 7'(n);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rnd%0d_accept: term not accepted within budget", k); end
      wait_out(lat, w_ok);
      n_checks++;
      if (!w_ok || lat != 2) begin n_fail++; $display("FAIL rnd%0d_latency: wait %0d ok %0b expected 2", k, lat, w_ok); end
      exp_data = exp_q.pop_front();
      n_checks++;
      if (bus.out_data !== exp_data) begin n_fail++; $display("FAIL rnd%0d_data: got %0h expected %0h", k, bus.out_data, exp_data); end
      n_checks++;
      if (bus.term_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd%0d_cnt: got %0d expected %0d", k, bus.term_cnt, exp_cnt); end
      pop_out($urandom_range(0, 3));
    end
  endtask

  // out_ready held high throughout; nodes issued back to back
  task automatic test_back_to_back();
    longint sum;
    bit ok, w_ok;
    int lat, n;
    logic [DW-1:0] exp_data;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.state !== IDLE || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_ready: state %0d valid %0b expected IDLE/0", bus.state, bus.out_valid);
    end
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        node_c[i] = int'($urandom_range(0, 64)) - 32;
        node_d[i] = int'($urandom_range(0, 255)) - 128;
      end
      send_node(n, k * 5 - 12, 1'b0, sum, ok);
      exp_q.push_back(model_node(sum, k * 5 - 12));
      wait_out(lat, w_ok);
      exp_data = exp_q.pop_front();
      n_checks++;
      if (!w_ok || bus.out_data !== exp_data) begin
        n_fail++; $display("FAIL b2b%0d_data: got %0h ok %0b expected %0h", k, bus.out_data, w_ok, exp_data);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
